writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 168 ++++++++++++++++
 tb/tb_writeback_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Purpose:
//   MEM/WB pipeline register plus writeback result selection for a 32-bit
//   in-order core. The register captures the Memory-stage fields. ResultW
//   is then formed combinationally from the registered fields only, so the
//   same value can serve as the forwarding source. Load results are
//   extracted and sign/zero extended here, in the writeback stage.
//
// Optional feature:
//   WB_RETIRE_COUNT_EN - when defined, InstRetW is a RETIRE_W-bit wrapping
//   count of retired instructions. When undefined, InstRetW is tied to zero
//   and no counter flops are built.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   StallW      in   hold the MEM/WB register
//   FlushW      in   invalidate the MEM/WB register (wins over StallW)
//   ValidM      in   Memory stage holds a real instruction
//   RegWriteM   in   instruction writes the register file
//   ResultSrcM  in   [1:0] 00 ALU, 01 load, 10 PC+4, 11 reserved (zero)
//   LoadTypeM   in   [2:0] 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   RdM         in   [4:0] destination register
//   ALUResultM  in   [31:0] ALU result / load address
//   ReadDataM   in   [31:0] raw data-memory word
//   PCPlus4M    in   [31:0] PC+4
//   ValidW      out  WB register holds a real instruction
//   RegWriteW   out  qualified register-file write enable (never for x0)
//   RdW         out  [4:0] registered destination
//   ResultW     out  [31:0] writeback value / forwarding source
//   InstRetW    out  [RETIRE_W-1:0] retired-instruction count
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                StallW,
    input  logic                FlushW,
    input  logic                ValidM,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic [2:0]          LoadTypeM,
    input  logic [4:0]          RdM,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         ReadDataM,
    input  logic [31:0]         PCPlus4M,
    output logic                ValidW,
    output logic                RegWriteW,
    output logic [4:0]          RdW,
    output logic [31:0]         ResultW,
    output logic [RETIRE_W-1:0] InstRetW
);

    // Select and extend the addressed byte/halfword of a loaded word.
    // Unlisted load-type encodings fall through to the full word.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  load_type,
        input logic [1:0]  addr_lsb,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result_v;
        case (addr_lsb)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        // addr_lsb[0] is deliberately ignored for halfword loads.
        if (addr_lsb[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (load_type)
            3'b000:  result_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  result_v = {{16{half_v[15]}}, half_v};
            3'b100:  result_v = {24'h000000, byte_v};
            3'b101:  result_v = {16'h0000, half_v};
            default: result_v = word;
        endcase
        return result_v;
    endfunction

    logic        r_valid;
    logic        r_reg_write;
    logic [4:0]  r_rd;
    logic [1:0]  r_result_src;
    logic [2:0]  r_load_type;
    logic [31:0] r_alu_result;
    logic [31:0] r_read_data;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_result;

    // MEM/WB control bits: flush clears them and wins over stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (FlushW) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (!StallW) begin
            r_valid     <= ValidM;
            r_reg_write <= RegWriteM;
        end
    end

    // MEM/WB data fields: captured when the stage advances. A flushed
    // entry keeps its old data because it is marked invalid anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd         <= 5'd0;
            r_result_src <= 2'b00;
            r_load_type  <= 3'b000;
            r_alu_result <= 32'h0000_0000;
            r_read_data  <= 32'h0000_0000;
            r_pc_plus4   <= 32'h0000_0000;
        end else if (!FlushW && !StallW) begin
            r_rd         <= RdM;
            r_result_src <= ResultSrcM;
            r_load_type  <= LoadTypeM;
            r_alu_result <= ALUResultM;
            r_read_data  <= ReadDataM;
            r_pc_plus4   <= PCPlus4M;
        end
    end

    // Writeback mux, built from registered fields only.
    always_comb begin
        w_result = 32'h0000_0000;
        case (r_result_src)
            2'b00:   w_result = r_alu_result;
            2'b01:   w_result = load_extract(r_load_type, r_alu_result[1:0], r_read_data);
            2'b10:   w_result = r_pc_plus4;
            default: w_result = 32'h0000_0000;
        endcase
    end

    assign ValidW    = r_valid;
    assign RegWriteW = r_reg_write && r_valid && (r_rd != 5'd0);
    assign RdW       = r_rd;
    assign ResultW   = w_result;

`ifdef WB_RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] r_inst_ret;

    // Retire count: an instruction retires when it leaves a valid WB slot
    // on an unstalled edge, whether or not a flush hits the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_ret <= {RETIRE_W{1'b0}};
        end else if (r_valid && !StallW) begin
            r_inst_ret <= r_inst_ret + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign InstRetW = r_inst_ret;
`else
    assign InstRetW = {RETIRE_W{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        StallW;
    logic        FlushW;
    logic        ValidM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadTypeM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCPlus4M;
    logic        ValidW;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [63:0] InstRetW;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents of the WB slot as an abstract record.
    logic        m_valid;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_src;
    logic [2:0]  m_lt;
    logic [31:0] m_alu;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic [63:0] m_cnt;

    writeback_stage #(.RETIRE_W(64)) dut (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .LoadTypeM(LoadTypeM), .RdM(RdM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .InstRetW(InstRetW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected writeback value, computed arithmetically from the rules.
    function automatic logic [31:0] model_result();
        longint v;
        int     sh;
        if (m_src == 2'd0) return m_alu;
        if (m_src == 2'd2) return m_pc;
        if (m_src == 2'd3) return 32'h0;
        if (m_lt == 3'b000 || m_lt == 3'b100) begin
            sh = 8 * int'(m_alu[1:0]);
            v  = longint'((m_data >> sh) & 32'hFF);
            if (m_lt == 3'b000 && v >= 128) v = v - 256;
            return 32'(v);
        end
        if (m_lt == 3'b001 || m_lt == 3'b101) begin
            sh = m_alu[1] ? 16 : 0;
            v  = longint'((m_data >> sh) & 32'hFFFF);
            if (m_lt == 3'b001 && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return m_data;
    endfunction

    function automatic logic model_regwrite();
        return m_valid && m_rw && (m_rd != 5'd0);
    endfunction

    function automatic logic [63:0] model_instret();
`ifdef WB_RETIRE_COUNT_EN
        return m_cnt;
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_src = 2'd0; m_lt = 3'd0;
        m_alu = 32'h0; m_data = 32'h0; m_pc = 32'h0; m_cnt = 64'd0;
    endtask

    // Apply one rising edge with the currently driven inputs and advance the model.
    task automatic drive_edge();
        @(posedge clk);
        if (rst) begin
            if (m_valid && !StallW) m_cnt = m_cnt + 64'd1;
            if (FlushW) begin
                m_valid = 1'b0;
                m_rw    = 1'b0;
            end else if (!StallW) begin
                m_valid = ValidM; m_rw = RegWriteM; m_rd = RdM; m_src = ResultSrcM;
                m_lt = LoadTypeM; m_alu = ALUResultM; m_data = ReadDataM; m_pc = PCPlus4M;
            end
        end
        #1;
    endtask

    task automatic set_inputs(input logic v, input logic rw, input logic [1:0] src,
                              input logic [2:0] lt, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] data,
                              input logic [31:0] pc);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt; RdM = rd;
        ALUResultM = alu; ReadDataM = data; PCPlus4M = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
        set_inputs(1'b1, 1'b1, 2'd0, 3'd0, 5'd9, 32'hDEAD_BEEF, 32'h1, 32'h2);
        model_reset();
        repeat (2) drive_edge();
        n_checks++; if (ValidW !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", ValidW); end
        n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %0h exp 0", RegWriteW); end
        n_checks++; if (RdW !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0h exp 0", RdW); end
        n_checks++; if (ResultW !== 32'h0) begin n_fail++; $display("FAIL reset_result got %0h exp 0", ResultW); end
        n_checks++; if (InstRetW !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0h exp 0", InstRetW); end
        @(negedge clk);
        rst = 1'b1;
        set_inputs(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_edge();
    endtask

    task automatic test_alu_write();
        set_inputs(1'b1, 1'b1, 2'b00, 3'd0, 5'd5, 32'h0000_1234, 32'hAAAA_5555, 32'h100);
        drive_edge();
        set_inputs(1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        n_checks++; if (ValidW !== 1'b1) begin n_fail++; $display("FAIL alu_valid got %0h exp 1", ValidW); end
        n_checks++; if (RegWriteW !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite got %0h exp 1", RegWriteW); end
        n_checks++; if (RdW !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0h exp 5", RdW); end
        n_checks++; if (ResultW !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_result got %0h exp 1234", ResultW); end
    endtask

    task automatic test_loads();
        logic [2:0]  lt [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [4]  = '{32'h3, 32'h3, 32'h2, 32'h3};
        logic [31:0] ex [4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b1, 1'b1, 2'b01, lt[i], 5'd3, ad[i], 32'h80FF_7F01, 32'h0);
            drive_edge();
            n_checks++;
            if (ResultW !== ex[i])
                begin n_fail++; $display("FAIL load_%0d got %0h exp %0h", i, ResultW, ex[i]); end
        end
        // PC+4 and reserved select
        set_inputs(1'b1, 1'b1, 2'b10, 3'd0, 5'd1, 32'h5, 32'h6, 32'h0000_0444);
        drive_edge();
        n_checks++; if (ResultW !== 32'h0000_0444) begin n_fail++; $display("FAIL pc4_result got %0h exp 444", ResultW); end
        set_inputs(1'b1, 1'b1, 2'b11, 3'd0, 5'd1, 32'h5, 32'h6, 32'h7);
        drive_edge();
        n_checks++; if (ResultW !== 32'h0) begin n_fail++; $display("FAIL rsvd_result got %0h exp 0", ResultW); end
    endtask

    task automatic test_stall();
        logic [63:0] cnt0;
        set_inputs(1'b1, 1'b1, 2'b01, 3'b000, 5'd7, 32'h1, 32'h0000_8000, 32'h0);
        drive_edge();
        cnt0 = model_instret();
        StallW = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 1'b1, 2'($urandom), 3'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            drive_edge();
            n_checks++; if (RdW !== 5'd7) begin n_fail++; $display("FAIL stall_rd_%0d got %0h exp 7", i, RdW); end
            n_checks++; if (ResultW !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL stall_result_%0d got %0h exp ffffff80", i, ResultW); end
            n_checks++; if (InstRetW !== cnt0) begin n_fail++; $display("FAIL stall_instret_%0d got %0h exp %0h", i, InstRetW, cnt0); end
        end
        StallW = 1'b0;
        set_inputs(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_edge();
`ifdef WB_RETIRE_COUNT_EN
        cnt0 = cnt0 + 64'd1;
`endif
        n_checks++; if (InstRetW !== cnt0) begin n_fail++; $display("FAIL release_instret got %0h exp %0h", InstRetW, cnt0); end
        n_checks++; if (ValidW !== 1'b0) begin n_fail++; $display("FAIL release_valid got %0h exp 0", ValidW); end
    endtask

    task automatic test_flush_x0();
        set_inputs(1'b1, 1'b1, 2'b00, 3'd0, 5'd4, 32'h77, 32'h0, 32'h0);
        drive_edge();
        StallW = 1'b1; FlushW = 1'b1;
        drive_edge();
        StallW = 1'b0; FlushW = 1'b0;
        n_checks++; if (ValidW !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0h exp 0", ValidW); end
        n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite got %0h exp 0", RegWriteW); end
        set_inputs(1'b1, 1'b1, 2'b00, 3'd0, 5'd0, 32'h99, 32'h0, 32'h0);
        drive_edge();
        n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL x0_regwrite got %0h exp 0", RegWriteW); end
        n_checks++; if (ValidW !== 1'b1) begin n_fail++; $display("FAIL x0_valid got %0h exp 1", ValidW); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            StallW = ($urandom_range(0, 3) == 0);
            FlushW = ($urandom_range(0, 9) == 0);
            set_inputs(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
                       5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom, $urandom);
            drive_edge();
            n_checks++; if (ValidW !== m_valid) begin n_fail++; $display("FAIL rnd_valid_%0d got %0h exp %0h", i, ValidW, m_valid); end
            n_checks++; if (RegWriteW !== model_regwrite()) begin n_fail++; $display("FAIL rnd_regwrite_%0d got %0h exp %0h", i, RegWriteW, model_regwrite()); end
            n_checks++; if (RdW !== m_rd) begin n_fail++; $display("FAIL rnd_rd_%0d got %0h exp %0h", i, RdW, m_rd); end
            n_checks++; if (ResultW !== model_result()) begin n_fail++; $display("FAIL rnd_result_%0d got %0h exp %0h", i, ResultW, model_result()); end
            n_checks++; if (InstRetW !== model_instret()) begin n_fail++; $display("FAIL rnd_instret_%0d got %0h exp %0h", i, InstRetW, model_instret()); end
        end
        StallW = 1'b0; FlushW = 1'b0;
    endtask

    task automatic test_wrap();
`ifdef WB_RETIRE_COUNT_EN
        set_inputs(1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_edge();
        force dut.r_inst_ret = {64{1'b1}};
        #1;
        release dut.r_inst_ret;
        m_cnt = {64{1'b1}};
        drive_edge();
        n_checks++; if (InstRetW !== 64'd0) begin n_fail++; $display("FAIL wrap_instret got %0h exp 0", InstRetW); end
`endif
    endtask

    task automatic test_mid_reset();
        set_inputs(1'b1, 1'b1, 2'b00, 3'd0, 5'd12, 32'hCAFE_F00D, 32'h0, 32'h0);
        drive_edge();
        rst = 1'b0;
        #1;
        n_checks++; if (ValidW !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0h exp 0", ValidW); end
        n_checks++; if (ResultW !== 32'h0) begin n_fail++; $display("FAIL midrst_result got %0h exp 0", ResultW); end
        n_checks++; if (RdW !== 5'd0) begin n_fail++; $display("FAIL midrst_rd got %0h exp 0", RdW); end
        n_checks++; if (InstRetW !== 64'd0) begin n_fail++; $display("FAIL midrst_instret got %0h exp 0", InstRetW); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_stall();
        test_flush_x0();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
